// File: rtl/colony_world_writer_if.sv
// colony_world_writer_if: ant-array and world-grid signals around the world writer
interface colony_world_writer_if #(
  parameter int NUM_ANTS    = 8,
  parameter int X_bits      = 9,
  parameter int Y_bits      = 9,
  parameter int SIGNAL_bits = 4,
  parameter int SUGAR_bits  = 4
);
  logic                            start;
  logic [NUM_ANTS*X_bits-1:0]      ant_X;
  logic [NUM_ANTS*Y_bits-1:0]      ant_Y;
  logic [NUM_ANTS-1:0]             ant_mouthFull;
  logic [NUM_ANTS-1:0]             ant_collecting;
  logic [NUM_ANTS-1:0]             ant_dropping;
  logic                            moveNow;
  logic                            global_writing_flag;
  logic [X_bits-1:0]               mem_X;
  logic [Y_bits-1:0]               mem_Y;
  logic                            mem_rd;
  logic [SIGNAL_bits+SUGAR_bits-1:0] mem_rdata;
  logic                            mem_we;
  logic [SIGNAL_bits+SUGAR_bits-1:0] mem_wdata;
  logic [15:0]                     nest_sugar;
  logic                            busy;
  logic                            done;
  modport master (
    input  start, ant_X, ant_Y, ant_mouthFull, ant_collecting, ant_dropping, mem_rdata,
    output moveNow, global_writing_flag, mem_X, mem_Y, mem_rd, mem_we, mem_wdata,
           nest_sugar, busy, done
  );
  modport slave (
    output start, ant_X, ant_Y, ant_mouthFull, ant_collecting, ant_dropping, mem_rdata,
    input  moveNow, global_writing_flag, mem_X, mem_Y, mem_rd, mem_we, mem_wdata,
           nest_sugar, busy, done
  );
endinterface

// File: rtl/colony_world_writer.sv
// colony_world_writer: per-step ant snapshot, move strobe, grid read-modify-write and re-arm strobe
module colony_world_writer #(
  parameter int NUM_ANTS    = 8,
  parameter int X_bits      = 9,
  parameter int Y_bits      = 9,
  parameter int SIGNAL_bits = 4,
  parameter int SUGAR_bits  = 4,
  parameter int DEPOSIT     = 3
) (
  input logic newLocClock,
  input logic RESET,
  colony_world_writer_if.master bus
);
  localparam int IW   = NUM_ANTS > 1 ? $clog2(NUM_ANTS) : 1;
  localparam int W    = SIGNAL_bits + SUGAR_bits;
  localparam int SMAX = 2**SIGNAL_bits - 1;
  typedef enum logic [3:0] {IDLE, SNAP, MOVE, CHECK, RD, WAIT, WR, FLAG, DONE} state_t;
  state_t state, next;
  logic [IW-1:0]              idx;
  logic [NUM_ANTS*X_bits-1:0] snap_x;
  logic [NUM_ANTS*Y_bits-1:0] snap_y;
  logic [NUM_ANTS-1:0]        snap_mf, snap_col, snap_drop;
  logic [W-1:0]               rd_q;
  logic [X_bits-1:0]          mem_x_q;
  logic [Y_bits-1:0]          mem_y_q;
  logic [15:0]                nest_q;
  logic                       active, last;
  logic [SUGAR_bits-1:0]      sug, sug_n;
  logic [SIGNAL_bits-1:0]     sig, sig_n;
  logic [SIGNAL_bits:0]       sum;
  assign active = snap_mf[idx] | snap_col[idx] | snap_drop[idx];
  assign last   = idx == IW'(NUM_ANTS - 1);
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = bus.start ? SNAP : IDLE;
      SNAP:    next = MOVE;
      MOVE:    next = CHECK;
      CHECK:   next = active ? RD : last ? FLAG : CHECK;
      RD:      next = WAIT;
      WAIT:    next = WR;
      WR:      next = last ? FLAG : CHECK;
      FLAG:    next = DONE;
      default: next = IDLE;
    endcase
  end
  // Flags are captured in SNAP, one cycle before moveNow lets the ants change them.
  always_ff @(posedge newLocClock or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      idx       <= '0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_mf   <= '0;
      snap_col  <= '0;
      snap_drop <= '0;
      rd_q      <= '0;
      mem_x_q   <= '0;
      mem_y_q   <= '0;
      nest_q    <= '0;
    end else begin
      state <= next;
      if (state == SNAP) begin
        snap_x    <= bus.ant_X;
        snap_y    <= bus.ant_Y;
        snap_mf   <= bus.ant_mouthFull;
        snap_col  <= bus.ant_collecting;
        snap_drop <= bus.ant_dropping;
      end
      if (state == MOVE) idx <= '0;
      if ((state == CHECK && !active) || state == WR) idx <= idx + 1'b1;
      if (state == CHECK && active) begin
        mem_x_q <= snap_x[idx*X_bits +: X_bits];
        mem_y_q <= snap_y[idx*Y_bits +: Y_bits];
      end
      if (state == WAIT) rd_q <= bus.mem_rdata;
      if (state == WR && snap_drop[idx] && nest_q != 16'hFFFF) nest_q <= nest_q + 16'd1;
    end
  end
  always_comb begin
    sug   = rd_q[SUGAR_bits-1:0];
    sig   = rd_q[W-1:SUGAR_bits];
    sum   = {1'b0, sig} + (SIGNAL_bits+1)'(DEPOSIT);
    sug_n = (snap_col[idx] && sug != '0) ? sug - SUGAR_bits'(1) : sug;
    sig_n = !snap_mf[idx] ? sig :
            sum > (SIGNAL_bits+1)'(SMAX) ? SIGNAL_bits'(SMAX) : sum[SIGNAL_bits-1:0];
  end
  assign bus.moveNow             = state == MOVE;
  assign bus.global_writing_flag = state == FLAG;
  assign bus.mem_rd              = state == RD;
  assign bus.mem_we              = state == WR;
  assign bus.mem_wdata           = state == WR ? {sig_n, sug_n} : '0;
  assign bus.mem_X               = mem_x_q;
  assign bus.mem_Y               = mem_y_q;
  assign bus.nest_sugar          = nest_q;
  assign bus.busy                = state != IDLE && state != DONE;
  assign bus.done                = state == DONE;
endmodule
